// File: rtl/down_counter_timer.sv
// Loadable down-counter/timer with one-shot and auto-reload modes.
// Optional en prescaler is built only when PRESCALE_EN is defined.
module down_counter_timer #(
    parameter int WIDTH    = 4,
    parameter int PRESCALE = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    input  logic             auto_reload,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             zero,
    output logic             tc
);

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] reload_reg, reload_nxt, count_nxt;
    logic             tc_nxt;
    logic             tick;

    if (WIDTH < 2 || PRESCALE < 2) begin : g_bad_cfg
        $error("down_counter_timer: WIDTH and PRESCALE must both be >= 2");
    end

`ifdef PRESCALE_EN
    localparam int PW = $clog2(PRESCALE);

    logic [PW-1:0] pre_cnt, pre_nxt;

    // The prescaler only advances while a count is actually running.
    always_comb begin
        pre_nxt = pre_cnt;
        tick    = 1'b0;
        if (load || state != RUN) begin
            pre_nxt = '0;
        end else if (en) begin
            if (pre_cnt == PW'(PRESCALE - 1)) begin
                tick    = 1'b1;
                pre_nxt = '0;
            end else begin
                pre_nxt = pre_cnt + PW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pre_cnt <= '0;
        else        pre_cnt <= pre_nxt;
    end
`else
    assign tick = en;
`endif

    always_comb begin
        state_nxt  = state;
        count_nxt  = count;
        reload_nxt = reload_reg;
        tc_nxt     = 1'b0;
        if (load) begin
            count_nxt  = load_val;
            reload_nxt = load_val;
            state_nxt  = (load_val != '0) ? RUN : IDLE;
        end else if (state == RUN && tick) begin
            if (count > WIDTH'(1)) begin
                count_nxt = count - WIDTH'(1);
            end else begin
                // Terminal tick: mode is sampled only here.
                tc_nxt = 1'b1;
                if (auto_reload) begin
                    count_nxt = reload_reg;
                end else begin
                    count_nxt = '0;
                    state_nxt = IDLE;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            count      <= '0;
            reload_reg <= '0;
            tc         <= 1'b0;
        end else begin
            state      <= state_nxt;
            count      <= count_nxt;
            reload_reg <= reload_nxt;
            tc         <= tc_nxt;
        end
    end

    assign busy = (state == RUN);
    assign zero = (count == '0);

endmodule

// File: tb/tb_down_counter_timer.sv
// Scoreboard bench for down_counter_timer: random and directed stimulus,
// expected outputs from a behavioural model, checked by a separate monitor.
module tb_down_counter_timer;

    localparam int WIDTH    = 4;
    localparam int PRESCALE = 4;
    localparam int MAXV     = (1 << WIDTH) - 1;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             load = 1'b0;
    logic [WIDTH-1:0] load_val = '0;
    logic             en = 1'b0;
    logic             auto_reload = 1'b0;
    logic [WIDTH-1:0] count;
    logic             busy, zero, tc;

    down_counter_timer #(.WIDTH(WIDTH), .PRESCALE(PRESCALE)) dut (
        .clk(clk), .rst_n(rst_n), .load(load), .load_val(load_val), .en(en),
        .auto_reload(auto_reload), .count(count), .busy(busy), .zero(zero), .tc(tc)
    );

    always #5 clk = ~clk;

    typedef struct {
        int count;
        bit busy;
        bit zero;
        bit tc;
        int idx;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   failures = 0;
    int   step_idx = 0;

    // Model: "remaining" ticks until terminal, plus the period to restart with.
    int m_remain = 0;
    int m_period = 0;
    bit m_running = 0;
    bit m_tc = 0;
    int m_sub = 0;

    task automatic check(input string name, input int idx, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s step=%0d actual=%0d expected=%0d", name, idx, act, exp);
        end
    endtask

    function automatic void model_reset();
        m_remain = 0; m_period = 0; m_running = 0; m_tc = 0; m_sub = 0;
    endfunction

    function automatic void model_step(input bit ld, input int lv, input bit e, input bit ar);
        bit ticked;
        m_tc = 0;
        if (ld) begin
            m_remain = lv; m_period = lv; m_running = (lv != 0); m_sub = 0;
            return;
        end
        if (!m_running) begin
            m_sub = 0;
            return;
        end
`ifdef PRESCALE_EN
        ticked = 0;
        if (e) begin
            m_sub = m_sub + 1;
            if (m_sub == PRESCALE) begin ticked = 1; m_sub = 0; end
        end
`else
        ticked = e;
`endif
        if (!ticked) return;
        m_remain = m_remain - 1;
        if (m_remain == 0) begin
            m_tc = 1;
            if (ar) m_remain = m_period;
            else m_running = 0;
        end
    endfunction

    // Drive one cycle of inputs, advance the model, queue the expected result.
    task automatic cyc(input bit ld, input int lv, input bit e, input bit ar);
        exp_t x;
        @(negedge clk);
        load = ld; load_val = WIDTH'(lv); en = e; auto_reload = ar;
        model_step(ld, lv, e, ar);
        x.count = m_remain; x.busy = m_running; x.zero = (m_remain == 0);
        x.tc = m_tc; x.idx = step_idx++;
        exp_q.push_back(x);
    endtask

    initial begin : monitor
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                x = exp_q.pop_front();
                check("count", x.idx, int'(count), x.count);
                check("busy",  x.idx, int'(busy),  int'(x.busy));
                check("zero",  x.idx, int'(zero),  int'(x.zero));
                check("tc",    x.idx, int'(tc),    int'(x.tc));
            end
        end
    end

    initial begin : stim
        bit ar_r;
        #2;
        check("rst_count", -1, int'(count), 0);
        check("rst_zero",  -1, int'(zero),  1);
        check("rst_busy",  -1, int'(busy),  0);
        check("rst_tc",    -1, int'(tc),    0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;

        repeat (3) cyc(0, 0, 1, 0);                       // idle at 0, no wrap
        cyc(1, 5, 1, 0); repeat (25) cyc(0, 0, 1, 0);     // one-shot
        cyc(1, 3, 1, 1); repeat (30) cyc(0, 0, 1, 1);     // periodic
        cyc(1, 4, 1, 0);
        cyc(0, 0, 1, 0); cyc(0, 0, 0, 0); cyc(0, 0, 1, 0); cyc(0, 0, 0, 0);
        repeat (20) cyc(0, 0, 1, 0);                      // enable gating
        cyc(1, 2, 1, 0); repeat (12) cyc(0, 0, 1, 0);     // prescaled delay
        // Load lands on the terminal tick of an auto-reload run.
        cyc(1, 1, 1, 1);
`ifdef PRESCALE_EN
        repeat (PRESCALE - 1) cyc(0, 0, 1, 1);
`endif
        cyc(1, 7, 1, 1);
        repeat (3) cyc(0, 0, 1, 0);
        cyc(1, 0, 1, 0); repeat (3) cyc(0, 0, 1, 0);      // load 0 -> idle
        cyc(1, MAXV, 1, 0); repeat (70) cyc(0, 0, 1, 0);  // full range

        // Asynchronous reset mid-run.
        cyc(1, 5, 1, 0); repeat (3) cyc(0, 0, 1, 0);
        @(negedge clk);
        en = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("arst_count", step_idx, int'(count), 0);
        check("arst_busy",  step_idx, int'(busy),  0);
        check("arst_tc",    step_idx, int'(tc),    0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) cyc(0, 0, 1, 0);

        ar_r = 0;
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 15) == 0) ar_r = ~ar_r;
            if ($urandom_range(0, 11) == 0)
                cyc(1, ($urandom_range(0, 3) == 0) ? $urandom_range(0, MAXV) : $urandom_range(0, 4),
                    ($urandom_range(0, 3) != 0), ar_r);
            else
                cyc(0, $urandom_range(0, MAXV), ($urandom_range(0, 3) != 0), ar_r);
        end

        repeat (3) @(negedge clk);
        check("queue_drained", step_idx, exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
